// File: rtl/cache_controller_if.sv
// Signal bundle between the miss-handling controller, the cache set array, the CPU
// request port and the memory req/ready port.
interface cache_controller_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned TAG_W  = 26;
  localparam int unsigned CTL_W  = 7;

  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] Addr;
  logic              Hit;
  logic              Dirty;
  logic [TAG_W-1:0]  OutTag;
  logic [ADDR_W-1:0] SetReadData;
  logic [CTL_W-1:0]  Ctls;
  logic              Stall;
  logic              MemReq;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [ADDR_W-1:0] MemWData;
  logic              MemReady;

  modport master (
    input  MemRead, MemWrite, Addr, Hit, Dirty, OutTag, SetReadData, MemReady,
    output Ctls, Stall, MemReq, MemWe, MemAddr, MemWData
  );

  modport slave (
    output MemRead, MemWrite, Addr, Hit, Dirty, OutTag, SetReadData, MemReady,
    input  Ctls, Stall, MemReq, MemWe, MemAddr, MemWData
  );
endinterface

// File: rtl/cache_controller.sv
// Miss-handling controller for the 4-way data cache: hit control, dirty writeback and
// 4-word refill over a req/ready memory port. Outputs are combinational by design.
module cache_controller (
  input  logic               CLK,
  input  logic               Reset,
  cache_controller_if.master bus
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned K_W    = 2;

  typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [K_W-1:0]    r_k;
  logic [K_W-1:0]    w_k_nxt;

  logic              w_req;
  logic              w_wen;
  logic              w_set_valid;
  logic              w_set_dirty;
  logic [K_W-1:0]    w_offset;
  logic              w_init;
  logic              w_offset_sw;
  logic              w_stall;
  logic              w_mem_req;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [ADDR_W-1:0] w_mem_wdata;
  logic              w_unused;

  assign w_req    = bus.MemRead | bus.MemWrite;
  assign w_unused = &{1'b0, bus.Addr[1:0]};

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_wen       = 1'b0;
    w_set_valid = 1'b0;
    w_set_dirty = 1'b0;
    w_offset    = '0;
    w_init      = 1'b0;
    w_offset_sw = 1'b0;
    w_stall     = 1'b0;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;

    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_init   = 1'b1;
          w_offset = bus.Addr[3:2];
          if (bus.Hit) begin
            // store wins when both requests are raised together
            if (bus.MemWrite) begin
              w_wen       = 1'b1;
              w_set_valid = 1'b1;
              w_set_dirty = 1'b1;
              w_offset_sw = 1'b1;
            end
          end else begin
            w_stall     = 1'b1;
            w_state_nxt = bus.Dirty ? WB : REFILL;
          end
        end
      end

      WB: begin
        w_stall     = 1'b1;
        w_mem_req   = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = {bus.OutTag, bus.Addr[5:4], r_k, 2'b00};
        w_mem_wdata = bus.SetReadData;
        w_offset    = r_k;
        if (bus.MemReady) begin
          if (r_k == 2'd3) w_state_nxt = REFILL;
          else             w_k_nxt     = r_k + 2'd1;
        end
      end

      REFILL: begin
        w_stall     = 1'b1;
        w_mem_req   = 1'b1;
        w_mem_addr  = {bus.Addr[31:4], r_k, 2'b00};
        w_offset    = r_k;
        w_wen       = bus.MemReady;
        // way turns valid only with the last word of the block
        w_set_valid = bus.MemReady & (r_k == 2'd3);
        if (bus.MemReady) begin
          if (r_k == 2'd3) w_state_nxt = IDLE;
          else             w_k_nxt     = r_k + 2'd1;
        end
      end

      default: w_state_nxt = IDLE;
    endcase

    if (w_state_nxt != r_state) w_k_nxt = '0;
  end

  // Reset silences everything except the stall, which still reflects the CPU request.
  assign bus.Ctls     = Reset ? {w_wen, w_set_valid, w_set_dirty, w_offset, w_init, w_offset_sw}
                              : '0;
  assign bus.Stall    = w_stall;
  assign bus.MemReq   = Reset & w_mem_req;
  assign bus.MemWe    = Reset & w_mem_we;
  assign bus.MemAddr  = Reset ? w_mem_addr  : '0;
  assign bus.MemWData = Reset ? w_mem_wdata : '0;
endmodule
